muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the RISC-V M extension, sitting beside the ALU in stage E.
- Runs one radix-2 add/subtract-and-shift step per cycle.
- Handles operand sign conversion and result correction.
- Tells the hazard unit to stall the pipeline through BusyE until the result is ready.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RISC-V M-extension multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  // Encodings follow funct3 of the M-extension opcodes.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FIX,
    DONE
  } muldiv_state_t;

  // Absolute value when the operand is treated as signed; raw bits otherwise.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shared 33-bit adder does hi+operand (multiply) or hi-operand (divide).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the sequencer decides when to use it.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic [W:0]   hi,
  input  logic [W-1:0] operand,
  input  logic         is_div,
  output logic [W:0]   hi_next,
  output logic         q_bit
);

  logic [W:0] addend;
  logic [W:0] res;
  logic       carry;

  // Subtraction is add of the inverted operand plus one; carry-out set means no borrow.
  assign addend         = is_div ? ~{1'b0, operand} : {1'b0, operand};
  assign {carry, res}   = {1'b0, hi} + {1'b0, addend} + {{(W+1){1'b0}}, is_div};
  assign q_bit          = is_div & carry;
  assign hi_next        = (is_div && !carry) ? hi : res;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer (radix-2, one step per cycle); MULDIV_EARLY_OUT_EN enables early finish.
// Latency: DoneE 35 cycles after accepted StartE (3 cycles for early-out cases when MULDIV_EARLY_OUT_EN).
// Backpressure: BusyE stalls the pipeline in INIT/RUN/FIX; StartE is ignored while busy; FlushE aborts.
module muldiv_seq #(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int CNT_W = muldiv_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] Op1E,
  input  logic [XLEN-1:0] Op2E,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);
  import muldiv_pkg::*;

  muldiv_state_t    state, state_nxt;
  muldiv_op_t       op_q;
  logic [XLEN-1:0]  op1_q, op2_q, opnd_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             n1_q, n2_q, div0_q, ovf_q;
  logic             accept, early;
  logic             is_div, sgn1, sgn2, div0, ovf;
  logic [XLEN-1:0]  mag1, mag2, quot, rem, fix_res;
  logic [XLEN:0]    step_in, step_hi, mul_acc;
  logic             q_bit;
  logic [2*XLEN-1:0] prod, prod_n;

  // Operand classification from the latched request.
  assign is_div = (op_q == DIV) || (op_q == DIVU) || (op_q == REM) || (op_q == REMU);
  assign sgn1   = (op_q == MULH) || (op_q == MULHSU) || (op_q == DIV) || (op_q == REM);
  assign sgn2   = (op_q == MULH) || (op_q == DIV) || (op_q == REM);
  assign mag1   = magnitude(op1_q, sgn1);
  assign mag2   = magnitude(op2_q, sgn2);
  assign div0   = (op2_q == '0);
  assign ovf    = is_div && sgn2 && (op1_q == INT_MIN) && (op2_q == DIV0_QUOT);

`ifdef MULDIV_EARLY_OUT_EN
  assign early  = is_div ? (div0 || ovf) : ((op1_q == '0) || (op2_q == '0));
`else
  assign early  = 1'b0;
`endif

  // Divide feeds the left-shifted remainder; multiply feeds the zero-extended accumulator.
  assign step_in = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};

  muldiv_step #(.W(XLEN)) u_step (
    .hi      (step_in),
    .operand (opnd_q),
    .is_div  (is_div),
    .hi_next (step_hi),
    .q_bit   (q_bit)
  );

  assign mul_acc = lo_q[0] ? step_hi : {1'b0, hi_q};

  // Sign correction and special-case selection, consumed only in FIX.
  assign prod   = {hi_q, lo_q};
  assign prod_n = (n1_q ^ n2_q) ? -prod : prod;
  assign quot   = (n1_q ^ n2_q) ? -lo_q : lo_q;
  assign rem    = n1_q ? -hi_q : hi_q;

  // Final result mux; divide-by-zero and signed overflow override the iterated value.
  always_comb begin
    fix_res = '0;
    case (op_q)
      MUL:                  fix_res = prod_n[XLEN-1:0];
      MULH, MULHSU, MULHU:  fix_res = prod_n[2*XLEN-1:XLEN];
      DIV, DIVU:            fix_res = div0_q ? DIV0_QUOT : (ovf_q ? INT_MIN : quot);
      default:              fix_res = div0_q ? op1_q : (ovf_q ? '0 : rem);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake outputs and request acceptance; flush overrides everything.
  always_comb begin
    state_nxt = state;
    BusyE     = 1'b0;
    DoneE     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (StartE) begin
          state_nxt = INIT;
          accept    = 1'b1;
        end
      end
      INIT: begin
        BusyE     = 1'b1;
        state_nxt = early ? FIX : RUN;
      end
      RUN: begin
        BusyE = 1'b1;
        if (&cnt_q) state_nxt = FIX;
      end
      FIX: begin
        BusyE     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        DoneE     = 1'b1;
        state_nxt = StartE ? INIT : IDLE;
        accept    = StartE;
      end
      default: state_nxt = IDLE;
    endcase
    if (FlushE) begin
      state_nxt = IDLE;
      accept    = 1'b0;
    end
  end

  // Datapath: capture on accept, set up in INIT, iterate in RUN, publish result leaving FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= MUL;
      op1_q   <= '0;
      op2_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      n1_q    <= 1'b0;
      n2_q    <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ResultE <= '0;
    end else begin
      if (accept) begin
        op_q  <= muldiv_op_t'(MulDivOpE);
        op1_q <= Op1E;
        op2_q <= Op2E;
      end
      if (state == INIT) begin
        cnt_q  <= '0;
        hi_q   <= '0;
        n1_q   <= sgn1 & op1_q[XLEN-1];
        n2_q   <= sgn2 & op2_q[XLEN-1];
        div0_q <= is_div & div0;
        ovf_q  <= ovf;
        opnd_q <= is_div ? mag2 : mag1;
        // A zero product skips RUN, so the accumulator must already hold zero.
        lo_q   <= early ? '0 : (is_div ? mag1 : mag2);
      end
      if (state == RUN) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (is_div) begin
          hi_q <= step_hi[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], q_bit};
        end else begin
          hi_q <= mul_acc[XLEN:1];
          lo_q <= {mul_acc[0], lo_q[XLEN-1:1]};
        end
      end
      if (state == FIX && state_nxt == DONE) ResultE <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed M-extension cases, flush/reset aborts, back-to-back, random.
// Latency: expects DoneE 35 cycles after the StartE cycle (3 for early-out cases when MULDIV_EARLY_OUT_EN).
// Backpressure: bench waits on DoneE with a bounded cycle budget.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] Op1E;
  logic [31:0] Op2E;
  logic        FlushE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;
  int          spec_lat;

  muldiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .Op1E      (Op1E),
    .Op2E      (Op2E),
    .FlushE    (FlushE),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .ResultE   (ResultE)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for RISC-V M semantics.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64, p;
    logic [63:0]        up;
    logic signed [31:0] sa, sbv, r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'b0, b};
    sa   = a;
    sbv  = b;
    up   = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: return up[31:0];
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * ub64; return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sbv;
        return r;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sbv;
        return r;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drive a request in the current cycle (cycle 0) and record its expected result.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    MulDivOpE = op;
    Op1E      = a;
    Op2E      = b;
    StartE    = 1'b1;
    sb.push_back(exp);
  endtask

  // Advance until DoneE; n is the cycle of DoneE counted from the StartE cycle, 0 on timeout.
  task automatic wait_done(output int n, output bit busy_ok);
    busy_ok = 1'b1;
    n       = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        StartE    = 1'b0;
        Op1E      = $urandom;
        Op2E      = $urandom;
        MulDivOpE = 3'($urandom);
      end
      if (DoneE) begin
        n = i;
        if (BusyE) busy_ok = 1'b0;
        break;
      end
      if (!BusyE) busy_ok = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    idle(3);
    checks++; if (BusyE !== 1'b0) $display("FAIL reset_busy: got %b want 0", BusyE); else passed++;
    checks++; if (DoneE !== 1'b0) $display("FAIL reset_done: got %b want 0", DoneE); else passed++;
    checks++; if (ResultE !== 32'd0) $display("FAIL reset_result: got %h want 00000000", ResultE); else passed++;
    reset = 1'b0;
    idle(2);
    checks++; if (BusyE !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", BusyE); else passed++;
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [31:0] av  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] ev  [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    int n; bit bok; logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], av[i], bv[i], ev[i]);
      wait_done(n, bok);
      exp = sb.pop_front();
      checks++; if (ResultE !== exp) $display("FAIL mul_result[%0d]: got %h want %h", i, ResultE, exp); else passed++;
      checks++; if (n != 35) $display("FAIL mul_latency[%0d]: DoneE in cycle %0d want 35", i, n); else passed++;
      checks++; if (!bok) $display("FAIL mul_busy[%0d]: BusyE not high in cycles 1..34 / low at done", i); else passed++;
      last_res = exp;
      idle(1);
      checks++; if (DoneE !== 1'b0) $display("FAIL mul_done_pulse[%0d]: got %b want 0", i, DoneE); else passed++;
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int n; bit bok; logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], av[i], bv[i], ev[i]);
      wait_done(n, bok);
      exp = sb.pop_front();
      checks++; if (ResultE !== exp) $display("FAIL div_result[%0d]: got %h want %h", i, ResultE, exp); else passed++;
      checks++; if (n != 35) $display("FAIL div_latency[%0d]: DoneE in cycle %0d want 35", i, n); else passed++;
      last_res = exp;
      idle(1);
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int n; bit bok; logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], av[i], bv[i], ev[i]);
      wait_done(n, bok);
      exp = sb.pop_front();
      checks++; if (ResultE !== exp) $display("FAIL special_result[%0d]: got %h want %h", i, ResultE, exp); else passed++;
      checks++; if (n != spec_lat) $display("FAIL special_latency[%0d]: DoneE in cycle %0d want %0d", i, n, spec_lat); else passed++;
      last_res = exp;
      idle(1);
    end
  endtask

  task automatic test_flush;
    bit seen;
    start_op(3'd0, 32'd3, 32'd5, 32'd15);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) StartE = 1'b0;
    end
    checks++; if (BusyE !== 1'b1) $display("FAIL flush_busy_before: got %b want 1", BusyE); else passed++;
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0;
    checks++; if (BusyE !== 1'b0) $display("FAIL flush_busy_after: got %b want 0", BusyE); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (DoneE) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL flush_no_done: got DoneE=1 want none"); else passed++;
    checks++; if (ResultE !== last_res) $display("FAIL flush_result_hold: got %h want %h", ResultE, last_res); else passed++;
    sb.delete();
    MulDivOpE = 3'd0; Op1E = 32'd2; Op2E = 32'd2;
    StartE = 1'b1; FlushE = 1'b1;
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;
    checks++; if (BusyE !== 1'b0) $display("FAIL start_flush_busy: got %b want 0", BusyE); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (DoneE || BusyE) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL start_flush_ignored: got activity want none"); else passed++;
  endtask

  task automatic test_back_to_back;
    int n; bit bok; logic [31:0] exp;
    start_op(3'd5, 32'd100, 32'd7, 32'd14);
    wait_done(n, bok);
    exp = sb.pop_front();
    checks++; if (ResultE !== exp) $display("FAIL b2b_first_result: got %h want %h", ResultE, exp); else passed++;
    start_op(3'd7, 32'd100, 32'd7, 32'd2);
    wait_done(n, bok);
    exp = sb.pop_front();
    checks++; if (n != 35) $display("FAIL b2b_latency: DoneE in cycle %0d want 35", n); else passed++;
    checks++; if (ResultE !== exp) $display("FAIL b2b_second_result: got %h want %h", ResultE, exp); else passed++;
    last_res = exp;
    idle(1);
    checks++; if (DoneE !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", DoneE); else passed++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    start_op(3'd0, 32'd9, 32'd9, 32'd81);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) StartE = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (BusyE !== 1'b0) $display("FAIL midreset_busy: got %b want 0", BusyE); else passed++;
    checks++; if (DoneE !== 1'b0) $display("FAIL midreset_done: got %b want 0", DoneE); else passed++;
    checks++; if (ResultE !== 32'd0) $display("FAIL midreset_result: got %h want 00000000", ResultE); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    last_res = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (DoneE) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL midreset_no_done: got DoneE=1 want none"); else passed++;
  endtask

  task automatic test_random;
    int n; bit bok; logic [2:0] op; logic [31:0] a, b, exp;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      start_op(op, a, b, ref_model(op, a, b));
      wait_done(n, bok);
      exp = sb.pop_front();
      checks++;
      if (ResultE !== exp) $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, ResultE, exp);
      else passed++;
      idle(1);
    end
  endtask

  initial begin
    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0;
    MulDivOpE = 3'd0; Op1E = 32'd0; Op2E = 32'd0;
    last_res = 32'd0;
`ifdef MULDIV_EARLY_OUT_EN
    spec_lat = 3;
`else
    spec_lat = 35;
`endif
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
